// File: rtl/fifo_wr_ctrl_lvl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_ctrl_lvl
// Description : Write-side controller of a dual-clock asynchronous FIFO
//               (W_CLK domain). Keeps the binary/Gray write pointers, the RAM
//               write address, registered full, fill level, a programmable
//               almost-full flag and a sticky overflow flag.
// Ports       : W_CLK, W_RST (async, active-low)
//               W_INC         write request
//               WQ2_RPTR      Gray read pointer, synchronised into W_CLK
//               AF_THRESH     almost-full threshold in entries
//               W_OVF_CLR     clear pulse for W_OVERFLOW
//               W_EN          combinational RAM write strobe
//               W_ADDR        RAM write address (next free slot)
//               W_PTR         registered Gray write pointer
//               W_FULL, W_ALMOST_FULL, W_LEVEL, W_OVERFLOW  registered status
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_ctrl_lvl #(
    parameter int ADDR_WIDTH = 3,
    parameter int PTR_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  W_CLK,
    input  logic                  W_RST,
    input  logic                  W_INC,
    input  logic [PTR_WIDTH-1:0]  WQ2_RPTR,
    input  logic [PTR_WIDTH-1:0]  AF_THRESH,
    input  logic                  W_OVF_CLR,
    output logic                  W_EN,
    output logic [ADDR_WIDTH-1:0] W_ADDR,
    output logic [PTR_WIDTH-1:0]  W_PTR,
    output logic                  W_FULL,
    output logic                  W_ALMOST_FULL,
    output logic [PTR_WIDTH-1:0]  W_LEVEL,
    output logic                  W_OVERFLOW
);

    logic [PTR_WIDTH-1:0] r_wbin;
    logic [PTR_WIDTH-1:0] r_wgray;
    logic [PTR_WIDTH-1:0] r_level;
    logic                 r_full;
    logic                 r_almost_full;
    logic                 r_overflow;

    logic                 w_accept;
    logic [PTR_WIDTH-1:0] w_wbin_next;
    logic [PTR_WIDTH-1:0] w_wgray_next;
    logic [PTR_WIDTH-1:0] w_rbin;
    logic [PTR_WIDTH-1:0] w_level_next;
    logic [PTR_WIDTH-1:0] w_rgray_full;

    // Acceptance uses the registered full flag so the RAM strobe never
    // depends on the read pointer combinationally.
    assign w_accept     = W_INC & ~r_full;
    assign w_wbin_next  = r_wbin + {{(PTR_WIDTH-1){1'b0}}, w_accept};
    assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at and
    // above its position.
    for (genvar gi = 0; gi < PTR_WIDTH; gi++) begin : g_g2b
        assign w_rbin[gi] = ^(WQ2_RPTR >> gi);
    end

    // Full means the write pointer is exactly one lap ahead of the read
    // pointer; in Gray code that is the top two bits inverted.
    assign w_rgray_full = {~WQ2_RPTR[PTR_WIDTH-1:PTR_WIDTH-2], WQ2_RPTR[PTR_WIDTH-3:0]};

    // Modulo subtraction; bounded by DEPTH because writes stop at full.
    assign w_level_next = w_wbin_next - w_rbin;

    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            r_wbin        <= '0;
            r_wgray       <= '0;
            r_level       <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_wbin        <= w_wbin_next;
            r_wgray       <= w_wgray_next;
            r_level       <= w_level_next;
            r_full        <= (w_wgray_next == w_rgray_full);
            r_almost_full <= (w_level_next >= AF_THRESH);
            // A rejected write sets the flag; setting wins over clearing.
            r_overflow    <= (W_INC & r_full) | (r_overflow & ~W_OVF_CLR);
        end
    end

    assign W_EN          = w_accept;
    assign W_ADDR        = r_wbin[ADDR_WIDTH-1:0];
    assign W_PTR         = r_wgray;
    assign W_FULL        = r_full;
    assign W_ALMOST_FULL = r_almost_full;
    assign W_LEVEL       = r_level;
    assign W_OVERFLOW    = r_overflow;

endmodule
`default_nettype wire
